md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Pipeline-side issue and stall controller for the multiply/divide unit. It sits between the E stage and the MDU. It forwards E-stage MDop requests to the MDU, pulses `start` for mult/multu/div/divu, and tracks the operation latency with an internal countdown. It stalls the D stage whenever a D-stage MD instruction would observe an in-flight operation.

## Interface
Parameters:
- `MULT_CYC`, default 5: busy cycles for mult/multu; legal range 1..2^CNT_W−1.
- `DIV_CYC`, default 10: busy cycles for div/divu; legal range 1..2^CNT_W−1.
- `CNT_W`, default 4: countdown width.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `e_valid`  in  1  E stage holds a real instruction, not a bubble.
- `e_mdop`  in  4  MDop of the E-stage instruction.
- `d_mdop`  in  4  MDop of the D-stage instruction; `nop_MDU` if it is not an MD instruction.
- `mdu_busy`  in  1  busy output of the MDU.
- `mdu_en`  out  1  MDU enable.
- `mdu_mdop`  out  4  MDop driven to the MDU.
- `start`  out  1  one-cycle launch pulse for mult/multu/div/divu.
- `stall_d`  out  1  freezes F/D and bubbles E.
- `cnt`  out  CNT_W  remaining busy cycles; 0 when idle.
- `md_err`  out  1  sticky protocol error; only present with MDU_BUSY_CHECK_EN.

## Operation
- MDop encoding: nop=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8.
- FSM states are IDLE and RUN.
- Launch ops (mult, multu, div, divu):
  - In IDLE with `e_valid` and a launch op: `start`=1 and `mdu_en`=1 combinationally.
  - Next edge: `cnt` loads MULT_CYC for mult/multu, DIV_CYC for div/divu; state goes to RUN.
- Other ops (mfhi, mflo, mthi, mtlo):
  - `e_valid` with one of these gives `mdu_en`=1 and `start`=0.
  - No state change.
- RUN:
  - `cnt` decrements each cycle.
  - When `cnt`==1, the next state is IDLE and `cnt` becomes 0.
- `mdu_mdop` = `e_mdop` when `e_valid`, otherwise `nop_MDU`. `mdu_en` = `e_valid` && (`e_mdop` != nop).
- Stall rule: `stall_d` = (`d_mdop` != nop) && (`start` || state==RUN).
- A launch op in E while in RUN cannot occur legally, because the D stall prevents it. If it does occur:
  - It is ignored: no `start`, no reload of `cnt`.
  - `md_err` is set when the error check is compiled in.
- Non-launch op in E during RUN: the controller does not gate it, since the MDU owns HI/LO ordering. It is flagged as an error as for launch ops.
- Reset: state IDLE, `cnt`=0, `md_err`=0. During the reset cycle `start`, `mdu_en` and `stall_d` are forced to 0.

## Timing
- Launch sampled at cycle T:
  - `start`=1 at T.
  - RUN during T+1 .. T+N, where N = MULT_CYC or DIV_CYC.
  - IDLE from T+N+1.
- `stall_d` may be high T .. T+N; never at T+N+1.
- `cnt` reads N at T+1 and 1 at T+N.
- `mdu_busy` is expected high exactly while in RUN.
- All state updates happen on the rising `clk` edge. `start`, `mdu_en` and `stall_d` are combinational from registered state and inputs.
- Reset mid-RUN: IDLE and `cnt`=0 at the next edge; `stall_d` is 0 in the reset cycle.
- Launch in E on the same cycle as the RUN→IDLE edge (`cnt`==1): cannot happen, because `stall_d` holds D. If forced, treat it as an error (RUN rule).

## Configuration
- Macro `MDU_BUSY_CHECK_EN`.
- Defined:
  - `md_err` port exists.
  - Sets sticky when `mdu_busy` != (state==RUN) in any non-reset cycle, or on an E-stage MD op during RUN.
  - Cleared only by `reset`.
- Undefined: no `md_err` port, `mdu_busy` is unused, and no comparison logic is generated.

## Structure
- MDop encodings (`nop_MDU` … `mtlo_MDU`), the FSM state codes, and the MULT_CYC/DIV_CYC defaults live in the shared `macro.v` include. They are not redefined locally.
- One sub-module, `md_latency_counter`:
  - Inputs: load, load value, clk, reset.
  - Outputs: `cnt`, a `last` flag (`cnt`==1), and `running`.
- The top level holds the decode, the stall logic and the error check.

## Test plan
- mult in E at T, `d_mdop`=mfhi → `start`=1 at T; `stall_d` high T..T+5; `cnt` 5,4,3,2,1 over T+1..T+5; IDLE and `stall_d`=0 at T+6.
- divu in E at T, D holds addu (nop) → `start`=1 at T, `stall_d`=0 throughout; `cnt`=10 at T+1, 0 at T+11.
- mthi in E with IDLE → `mdu_en`=1, `mdu_mdop`=7, `start`=0, `cnt` stays 0, no stall.
- div launched, `reset` asserted when `cnt`=4 → next cycle IDLE, `cnt`=0, `stall_d`=0 even with `d_mdop`=mflo.
- `e_valid`=0 with `e_mdop`=mult → `mdu_en`=0, `start`=0, `mdu_mdop`=0.
- With MDU_BUSY_CHECK_EN: mult launched, `mdu_busy` held 0 at T+1 → `md_err`=1 at T+2 and remains 1 until reset.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller: MDop encodings, FSM state
// codes, default operation latencies and small decode helpers.
package md_issue_ctrl_pkg;

    localparam logic [3:0] nop_mdu   = 4'd0;
    localparam logic [3:0] mult_mdu  = 4'd1;
    localparam logic [3:0] multu_mdu = 4'd2;
    localparam logic [3:0] div_mdu   = 4'd3;
    localparam logic [3:0] divu_mdu  = 4'd4;
    localparam logic [3:0] mfhi_mdu  = 4'd5;
    localparam logic [3:0] mflo_mdu  = 4'd6;
    localparam logic [3:0] mthi_mdu  = 4'd7;
    localparam logic [3:0] mtlo_mdu  = 4'd8;

    localparam int mult_cyc_def = 5;
    localparam int div_cyc_def  = 10;
    localparam int cnt_w_def    = 4;

    typedef enum logic {
        st_idle = 1'b0,
        st_run  = 1'b1
    } md_state_t;

    function automatic logic is_launch(input logic [3:0] op);
        return (op == mult_mdu) || (op == multu_mdu) ||
               (op == div_mdu)  || (op == divu_mdu);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == mult_mdu) || (op == multu_mdu);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter tracking the remaining busy cycles of an in-flight MDU op.
// Loads on launch, counts down to zero and then holds.
module md_latency_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             running
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last    = (cnt == CNT_W'(1));
    assign running = (cnt != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue and D-stall controller in front of the multiply/divide unit.
// Optional busy cross-check and sticky md_err port: define MDU_BUSY_CHECK_EN.
//
// state   | meaning
// st_idle | no MDU op in flight; launch ops in E are issued with start
// st_run  | mult/div in flight; cnt holds remaining busy cycles
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MULT_CYC = mult_cyc_def,
    parameter int DIV_CYC  = div_cyc_def,
    parameter int CNT_W    = cnt_w_def
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_mdop,
    input  logic [3:0]       d_mdop,
    input  logic             mdu_busy,
    output logic             mdu_en,
    output logic [3:0]       mdu_mdop,
    output logic             start,
    output logic             stall_d,
    output logic [CNT_W-1:0] cnt
`ifdef MDU_BUSY_CHECK_EN
    ,
    output logic             md_err
`endif
);

    md_state_t        state;
    md_state_t        state_nxt;
    logic             cnt_load;
    logic             cnt_last;
    logic             cnt_running;
    logic [CNT_W-1:0] load_val;
    logic             in_run;
    logic             launch_req;

    assign in_run     = (state == st_run);
    assign launch_req = e_valid && is_launch(e_mdop);
    assign load_val   = is_mult(e_mdop) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);

    md_latency_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (load_val),
        .cnt      (cnt),
        .last     (cnt_last),
        .running  (cnt_running)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        start     = 1'b0;
        case (state)
            st_idle: begin
                if (launch_req) begin
                    start     = 1'b1;
                    cnt_load  = 1'b1;
                    state_nxt = st_run;
                end
            end
            st_run: begin
                // Launches seen here are illegal and dropped; an empty counter
                // also releases RUN so a bad latency can never wedge the stall.
                if (cnt_last || !cnt_running) begin
                    state_nxt = st_idle;
                end
            end
            default: state_nxt = st_idle;
        endcase
        if (reset) begin
            start    = 1'b0;
            cnt_load = 1'b0;
        end
    end

    always_comb begin
        mdu_mdop = e_valid ? e_mdop : nop_mdu;
        mdu_en   = !reset && e_valid && (e_mdop != nop_mdu);
        stall_d  = !reset && (d_mdop != nop_mdu) && (start || in_run);
    end

`ifdef MDU_BUSY_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            md_err <= 1'b0;
        end else if ((mdu_busy != in_run) ||
                     (in_run && e_valid && (e_mdop != nop_mdu))) begin
            md_err <= 1'b1;
        end
    end
`else
    logic unused_busy;
    assign unused_busy = mdu_busy;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: per-cycle vector table through a
// scoreboard queue, plus hand sequences for stall length and the md_err check.
module tb_md_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       e_valid = 1'b0;
    logic [3:0] e_mdop = 4'd0;
    logic [3:0] d_mdop = 4'd0;
    logic       mdu_busy = 1'b0;
    logic       mdu_en;
    logic [3:0] mdu_mdop;
    logic       start;
    logic       stall_d;
    logic [3:0] cnt;
`ifdef MDU_BUSY_CHECK_EN
    logic       md_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    md_issue_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_mdop   (e_mdop),
        .d_mdop   (d_mdop),
        .mdu_busy (mdu_busy),
        .mdu_en   (mdu_en),
        .mdu_mdop (mdu_mdop),
        .start    (start),
        .stall_d  (stall_d),
        .cnt      (cnt)
`ifdef MDU_BUSY_CHECK_EN
        ,
        .md_err   (md_err)
`endif
    );

    typedef struct {
        logic       rst;
        logic       ev;
        logic [3:0] emd;
        logic [3:0] dmd;
        logic       x_start;
        logic       x_en;
        logic [3:0] x_mdop;
        logic       x_stall;
        logic [3:0] x_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic row(input logic rst, input logic ev, input logic [3:0] emd,
                       input logic [3:0] dmd, input logic xs, input logic xe,
                       input logic [3:0] xm, input logic xst, input logic [3:0] xc);
        tbl.push_back('{rst, ev, emd, dmd, xs, xe, xm, xst, xc});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   stall_cycles;

        // rst ev emd dmd | start en mdop stall cnt
        row(1, 1, 1, 5,  0, 0, 1, 0, 0);   // reset forces start/en/stall low
        row(0, 0, 1, 0,  0, 0, 0, 0, 0);   // e_valid=0 masks mult
        row(0, 1, 1, 5,  1, 1, 1, 1, 0);   // mult at T, mfhi in D
        for (int c = 5; c >= 1; c--) row(0, 0, 0, 5, 0, 0, 0, 1, 4'(c));
        row(0, 0, 0, 5,  0, 0, 0, 0, 0);   // T+6: idle, stall released
        row(0, 1, 5, 0,  0, 1, 5, 0, 0);   // mfhi issued without start
        row(0, 1, 4, 0,  1, 1, 4, 0, 0);   // divu, D not MD
        for (int c = 10; c >= 1; c--) row(0, 0, 0, 0, 0, 0, 0, 0, 4'(c));
        row(0, 0, 0, 0,  0, 0, 0, 0, 0);   // T+11
        row(0, 1, 7, 0,  0, 1, 7, 0, 0);   // mthi while idle
        row(0, 0, 0, 0,  0, 0, 0, 0, 0);
        row(0, 1, 3, 6,  1, 1, 3, 1, 0);   // div, mflo in D
        for (int c = 10; c >= 5; c--) row(0, 0, 0, 6, 0, 0, 0, 1, 4'(c));
        row(1, 0, 0, 6,  0, 0, 0, 0, 4);   // reset at cnt=4
        row(0, 0, 0, 6,  0, 0, 0, 0, 0);   // idle after reset
        row(0, 1, 1, 0,  1, 1, 1, 0, 0);   // mult
        row(0, 1, 3, 5,  0, 1, 3, 1, 5);   // illegal div during RUN: ignored
        row(0, 0, 0, 0,  0, 0, 0, 0, 4);
        row(0, 0, 0, 0,  0, 0, 0, 0, 3);
        row(0, 0, 0, 0,  0, 0, 0, 0, 2);
        row(0, 1, 2, 0,  0, 1, 2, 0, 1);   // multu on the last RUN cycle
        row(0, 0, 0, 0,  0, 0, 0, 0, 0);   // no reload
        row(0, 0, 0, 0,  0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset    = tbl[i].rst;
            e_valid  = tbl[i].ev;
            e_mdop   = tbl[i].emd;
            d_mdop   = tbl[i].dmd;
            mdu_busy = (tbl[i].x_cnt != 4'd0);
            sb.push_back(tbl[i]);
            #1;
            v = sb.pop_front();
            chk($sformatf("row%0d start", i),    32'(start),    32'(v.x_start));
            chk($sformatf("row%0d mdu_en", i),   32'(mdu_en),   32'(v.x_en));
            chk($sformatf("row%0d mdu_mdop", i), 32'(mdu_mdop), 32'(v.x_mdop));
            chk($sformatf("row%0d stall_d", i),  32'(stall_d),  32'(v.x_stall));
            chk($sformatf("row%0d cnt", i),      32'(cnt),      32'(v.x_cnt));
        end

        // Stall length for a mult with an MD op held in D: T..T+5 is 6 cycles.
        @(negedge clk);
        reset = 1'b1; e_valid = 1'b0; e_mdop = 4'd0; d_mdop = 4'd0; mdu_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0; e_valid = 1'b1; e_mdop = 4'd1; d_mdop = 4'd5;
        stall_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall_d) break;
            stall_cycles++;
            @(negedge clk);
            e_valid = 1'b0; e_mdop = 4'd0;
            mdu_busy = 1'b1;
        end
        chk("stall_len", 32'(stall_cycles), 32'd6);
        chk("idle_cnt_after_stall", 32'(cnt), 32'd0);
        mdu_busy = 1'b0;

`ifdef MDU_BUSY_CHECK_EN
        @(negedge clk);
        reset = 1'b1; e_valid = 1'b0; e_mdop = 4'd0; d_mdop = 4'd0; mdu_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("md_err_after_reset", 32'(md_err), 32'd0);
        @(negedge clk);
        e_valid = 1'b1; e_mdop = 4'd1;           // T: launch, busy low is consistent
        @(negedge clk);
        e_valid = 1'b0; e_mdop = 4'd0;           // T+1: RUN but busy held low
        #1;
        chk("md_err_T1", 32'(md_err), 32'd0);
        @(negedge clk);
        mdu_busy = 1'b1;                          // T+2
        #1;
        chk("md_err_T2", 32'(md_err), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mdu_busy = (cnt != 4'd0);
            #1;
            chk($sformatf("md_err_sticky%0d", k), 32'(md_err), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1; mdu_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("md_err_cleared", 32'(md_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
